regfile_read_arbiter: RTL and testbench

- Shares one 16-entry register read path (a W-bit 16:1 select mux) among four requesters, e.g. decode A/B operand fetch, shifter operand, debug port.
- Performs round-robin arbitration and registers the 4-bit select that drives the mux.
- Waits a programmable settle time, then captures the mux output and returns it to the winner with a one-cycle valid pulse.
- Sits between the multi-cycle control unit and the register file read mux.

---
 rtl/regfile_read_arbiter.sv | 119 +++++++++++
 tb/tb_regfile_read_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter for a shared 16-entry register read mux: grants one of four
// requesters, drives a registered select, waits SETTLE cycles, then returns the mux data.
module regfile_read_arbiter #(
  parameter int W      = 32,
  parameter int SETTLE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  input  logic [3:0]   addr0,
  input  logic [3:0]   addr1,
  input  logic [3:0]   addr2,
  input  logic [3:0]   addr3,
  input  logic [W-1:0] mux_data,
  output logic [3:0]   sel,
  output logic [3:0]   gnt,
  output logic [3:0]   rvalid,
  output logic [W-1:0] rdata
);

  localparam int          NUM_REQ  = 4;
  localparam logic [3:0]  SETTLE_C = 4'(SETTLE);

  typedef enum logic [1:0] {ARB, WAIT, CAPT} state_t;

  state_t                          state, state_nxt;
  logic [3:0]                      cnt, cnt_d;
  logic [1:0]                      last, last_d;
  logic [1:0]                      win, win_d;
  logic [3:0]                      sel_d, gnt_d, rvalid_d;
  logic [W-1:0]                    rdata_d;
  logic [NUM_REQ-1:0]              eff;
  logic [NUM_REQ-1:0][3:0]         addr_a;
  logic [1:0]                      pick, idx;
  logic                            found;

  assign addr_a[0] = addr0;
  assign addr_a[1] = addr1;
  assign addr_a[2] = addr2;
  assign addr_a[3] = addr3;

  // The requester being handed its data this cycle must not immediately re-win.
  assign eff = req & ~rvalid;

  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = last + 2'(k);
      if (!found && eff[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (found) state_nxt = (SETTLE_C != 4'd0) ? WAIT : CAPT;
      WAIT:    if (cnt == 4'd1) state_nxt = CAPT;
      CAPT:    state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  always_comb begin
    sel_d    = sel;
    gnt_d    = gnt;
    rvalid_d = '0;
    rdata_d  = rdata;
    cnt_d    = cnt;
    last_d   = last;
    win_d    = win;
    case (state)
      ARB: if (found) begin
        gnt_d = 4'b0001 << pick;
        sel_d = addr_a[pick];
        cnt_d = SETTLE_C;
        win_d = pick;
      end
      WAIT: cnt_d = cnt - 4'd1;
      CAPT: begin
        rdata_d  = mux_data;
        rvalid_d = gnt;
        gnt_d    = '0;
        last_d   = win;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel    <= '0;
      gnt    <= '0;
      rvalid <= '0;
      rdata  <= '0;
      cnt    <= '0;
      last   <= 2'd3;
      win    <= '0;
    end else begin
      sel    <= sel_d;
      gnt    <= gnt_d;
      rvalid <= rvalid_d;
      rdata  <= rdata_d;
      cnt    <= cnt_d;
      last   <= last_d;
      win    <= win_d;
    end
  end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench: per-cycle vector table on a SETTLE=0 instance, hand sequences
// for settle timing and mid-read reset on SETTLE=3 / SETTLE=2 instances.
module tb_regfile_read_arbiter;

  logic        clk = 1'b0;
  logic        rst_n, rst_n3, rst_n2;
  logic [3:0]  req, a0, a1, a2, a3;
  logic [3:0]  req_s, s0, s1, s2, s3;
  logic [3:0]  sel, gnt, rv, sel3, gnt3, rv3, sel2, gnt2, rv2;
  logic [31:0] rd, rd3, rd2, md, md3, md2;
  logic [31:0] rf [16];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign md  = rf[sel];
  assign md3 = rf[sel3];
  assign md2 = rf[sel2];

  regfile_read_arbiter #(.W(32), .SETTLE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .req(req), .addr0(a0), .addr1(a1), .addr2(a2), .addr3(a3),
    .mux_data(md), .sel(sel), .gnt(gnt), .rvalid(rv), .rdata(rd));
  regfile_read_arbiter #(.W(32), .SETTLE(3)) u3 (
    .clk(clk), .rst_n(rst_n3), .req(req_s), .addr0(s0), .addr1(s1), .addr2(s2), .addr3(s3),
    .mux_data(md3), .sel(sel3), .gnt(gnt3), .rvalid(rv3), .rdata(rd3));
  regfile_read_arbiter #(.W(32), .SETTLE(2)) u2 (
    .clk(clk), .rst_n(rst_n2), .req(req_s), .addr0(s0), .addr1(s1), .addr2(s2), .addr3(s3),
    .mux_data(md2), .sel(sel2), .gnt(gnt2), .rvalid(rv2), .rdata(rd2));

  typedef struct {
    logic [3:0]  req;
    logic [15:0] addrs;   // {addr3, addr2, addr1, addr0}
    logic [3:0]  gnt;
    logic [3:0]  sel;
    logic [3:0]  rv;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(logic [3:0] r, logic [15:0] ad, logic [3:0] g,
                              logic [3:0] s, logic [3:0] v, logic [31:0] d);
    vec_t x;
    x.req = r; x.addrs = ad; x.gnt = g; x.sel = s; x.rv = v; x.rd = d;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_u0;
    req = '0; a0 = '0; a1 = '0; a2 = '0; a3 = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic run_rows(input int lo, input int hi, input string seg);
    for (int i = lo; i <= hi; i++) begin
      req = tbl[i].req;
      {a3, a2, a1, a0} = tbl[i].addrs;
      tick();
      chk($sformatf("%s[%0d].gnt", seg, i), {28'h0, gnt}, {28'h0, tbl[i].gnt});
      chk($sformatf("%s[%0d].sel", seg, i), {28'h0, sel}, {28'h0, tbl[i].sel});
      chk($sformatf("%s[%0d].rvalid", seg, i), {28'h0, rv}, {28'h0, tbl[i].rv});
      chk($sformatf("%s[%0d].rdata", seg, i), rd, tbl[i].rd);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 32'hA5A5_0000 | i;
    rf[5] = 32'hDEAD_BEEF;

    // single read, address change after grant: rows 0..5
    tbl.push_back(mk(4'b0001, 16'h0005, 4'b0001, 4'd5, 4'b0000, 32'h0));
    tbl.push_back(mk(4'b0000, 16'h0005, 4'b0000, 4'd5, 4'b0001, 32'hDEAD_BEEF));
    tbl.push_back(mk(4'b0000, 16'h0005, 4'b0000, 4'd5, 4'b0000, 32'hDEAD_BEEF));
    tbl.push_back(mk(4'b0010, 16'h0030, 4'b0010, 4'd3, 4'b0000, 32'hDEAD_BEEF));
    tbl.push_back(mk(4'b0010, 16'h0070, 4'b0000, 4'd3, 4'b0010, 32'hA5A5_0003));
    tbl.push_back(mk(4'b0000, 16'h0070, 4'b0000, 4'd3, 4'b0000, 32'hA5A5_0003));
    // round robin with all four requesting: rows 6..15
    tbl.push_back(mk(4'b1111, 16'hBA98, 4'b0001, 4'd8,  4'b0000, 32'h0));
    tbl.push_back(mk(4'b1111, 16'hBA98, 4'b0000, 4'd8,  4'b0001, 32'hA5A5_0008));
    tbl.push_back(mk(4'b1111, 16'hBA98, 4'b0010, 4'd9,  4'b0000, 32'hA5A5_0008));
    tbl.push_back(mk(4'b1111, 16'hBA98, 4'b0000, 4'd9,  4'b0010, 32'hA5A5_0009));
    tbl.push_back(mk(4'b1111, 16'hBA98, 4'b0100, 4'd10, 4'b0000, 32'hA5A5_0009));
    tbl.push_back(mk(4'b1111, 16'hBA98, 4'b0000, 4'd10, 4'b0100, 32'hA5A5_000A));
    tbl.push_back(mk(4'b1111, 16'hBA98, 4'b1000, 4'd11, 4'b0000, 32'hA5A5_000A));
    tbl.push_back(mk(4'b1111, 16'hBA98, 4'b0000, 4'd11, 4'b1000, 32'hA5A5_000B));
    tbl.push_back(mk(4'b1111, 16'hBA98, 4'b0001, 4'd8,  4'b0000, 32'hA5A5_000B));
    tbl.push_back(mk(4'b1111, 16'hBA98, 4'b0000, 4'd8,  4'b0001, 32'hA5A5_0008));
    // two-way alternation, then lone requester masked during its rvalid: rows 16..24
    tbl.push_back(mk(4'b0011, 16'h0098, 4'b0001, 4'd8, 4'b0000, 32'h0));
    tbl.push_back(mk(4'b0011, 16'h0098, 4'b0000, 4'd8, 4'b0001, 32'hA5A5_0008));
    tbl.push_back(mk(4'b0011, 16'h0098, 4'b0010, 4'd9, 4'b0000, 32'hA5A5_0008));
    tbl.push_back(mk(4'b0011, 16'h0098, 4'b0000, 4'd9, 4'b0010, 32'hA5A5_0009));
    tbl.push_back(mk(4'b0001, 16'h0098, 4'b0001, 4'd8, 4'b0000, 32'hA5A5_0009));
    tbl.push_back(mk(4'b0001, 16'h0098, 4'b0000, 4'd8, 4'b0001, 32'hA5A5_0008));
    tbl.push_back(mk(4'b0001, 16'h0098, 4'b0000, 4'd8, 4'b0000, 32'hA5A5_0008));
    tbl.push_back(mk(4'b0001, 16'h0098, 4'b0001, 4'd8, 4'b0000, 32'hA5A5_0008));
    tbl.push_back(mk(4'b0000, 16'h0098, 4'b0000, 4'd8, 4'b0001, 32'hA5A5_0008));

    req_s = '0; s0 = '0; s1 = '0; s2 = '0; s3 = '0;
    rst_n3 = 1'b0; rst_n2 = 1'b0;
    reset_u0();
    chk("reset.sel",    {28'h0, sel}, 32'h0);
    chk("reset.gnt",    {28'h0, gnt}, 32'h0);
    chk("reset.rvalid", {28'h0, rv},  32'h0);
    chk("reset.rdata",  rd,           32'h0);

    run_rows(0, 5, "single");
    reset_u0();
    run_rows(6, 15, "rr");
    reset_u0();
    run_rows(16, 24, "mask");

    // SETTLE=3: sel held 4 cycles, data captured at the last one
    rst_n3 = 1'b1;
    req_s = 4'b0100; s2 = 4'd15;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) begin
        req_s = '0;
        s2 = 4'd0;
        rf[15] = 32'h1234_5678;
      end
      chk($sformatf("settle.gnt@%0d", k), {28'h0, gnt3}, 32'h4);
      chk($sformatf("settle.sel@%0d", k), {28'h0, sel3}, 32'hF);
      chk($sformatf("settle.rvalid@%0d", k), {28'h0, rv3}, 32'h0);
    end
    tick();
    chk("settle.rvalid@5", {28'h0, rv3}, 32'h4);
    chk("settle.rdata@5",  rd3,          32'h1234_5678);
    chk("settle.gnt@5",    {28'h0, gnt3}, 32'h0);
    tick();
    chk("settle.rvalid@6", {28'h0, rv3}, 32'h0);

    // SETTLE=2: reset during WAIT, then pointer restarts at 3
    rst_n2 = 1'b1;
    req_s = 4'b0001; s0 = 4'd4;
    tick();
    chk("rstmid.gnt_pre", {28'h0, gnt2}, 32'h1);
    chk("rstmid.sel_pre", {28'h0, sel2}, 32'h4);
    #2 rst_n2 = 1'b0;
    #1;
    chk("rstmid.gnt_async", {28'h0, gnt2}, 32'h0);
    chk("rstmid.sel_async", {28'h0, sel2}, 32'h0);
    tick();
    tick();
    chk("rstmid.rvalid_held", {28'h0, rv2}, 32'h0);
    chk("rstmid.rdata_held",  rd2,          32'h0);
    req_s = 4'b1010; s0 = 4'd0; s1 = 4'd6; s3 = 4'd2;
    rst_n2 = 1'b1;
    tick();
    chk("rstmid.gnt_first", {28'h0, gnt2}, 32'h2);
    chk("rstmid.sel_first", {28'h0, sel2}, 32'h6);
    req_s = '0;
    tick();
    tick();
    tick();
    chk("rstmid.rvalid", {28'h0, rv2}, 32'h2);
    chk("rstmid.rdata",  rd2,          32'hA5A5_0006);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
